// File: rtl/fwd_operand_mux_reg_pkg.sv
// Shared constants for the operand forwarding mux: select-mode encodings and forward source indices.
// Latency: none (definitions only).
// Backpressure: not applicable.
package fwd_operand_mux_reg_pkg;

  // Select mode encodings
  localparam logic SEL_MODE_ENC    = 1'b0;
  localparam logic SEL_MODE_ONEHOT = 1'b1;

  // Mapping of the existing forward codes to source bus indices
  localparam int FWD_IDX_ID  = 0;
  localparam int FWD_IDX_WB  = 1;
  localparam int FWD_IDX_MEM = 2;

endpackage

// File: rtl/fwd_operand_mux_reg_if.sv
// Handshake and data bundle between the forwarding stage and the operand register.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; the slave side is the mux block.
interface fwd_operand_mux_reg_if #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_SRC     = 4,
  parameter int ENC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int CNT_W       = 4
);
  logic [NUM_SRC*WORD_LENGTH-1:0] src_bus;
  logic                           sel_mode;
  logic [ENC_W-1:0]               sel_enc;
  logic [NUM_SRC-1:0]             sel_oh;
  logic                           in_valid;
  logic                           in_ready;
  logic                           flush;
  logic [WORD_LENGTH-1:0]         out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_nomatch;
  logic [CNT_W-1:0]               hold_cnt;

  modport master (
    output src_bus, sel_mode, sel_enc, sel_oh, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, out_nomatch, hold_cnt
  );

  modport slave (
    input  src_bus, sel_mode, sel_enc, sel_oh, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, out_nomatch, hold_cnt
  );
endinterface

// File: rtl/fwd_operand_mux_reg_fwd_sel_resolve.sv
// Combinational source resolution: encoded or lowest-index-wins one-hot select, falling back to last_val.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle, consumed only on accept.
module fwd_sel_resolve
  import fwd_operand_mux_reg_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_SRC     = 4,
  parameter int ENC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC*WORD_LENGTH-1:0] src_bus_i,
  input  logic                           sel_mode_i,
  input  logic [ENC_W-1:0]               sel_enc_i,
  input  logic [NUM_SRC-1:0]             sel_oh_i,
  input  logic [WORD_LENGTH-1:0]         last_val_i,
  output logic [WORD_LENGTH-1:0]         result_o,
  output logic                           match_o
);

  // Pick the selected source; out-of-range code or empty one-hot leaves the held value
  always_comb begin
    match_o  = 1'b0;
    result_o = last_val_i;
    if (sel_mode_i == SEL_MODE_ENC) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (sel_enc_i == ENC_W'(k)) begin
          match_o  = 1'b1;
          result_o = src_bus_i[k*WORD_LENGTH +: WORD_LENGTH];
        end
      end
    end else begin
      // Walk downwards so the lowest set bit is the last, winning assignment
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        if (sel_oh_i[k]) begin
          match_o  = 1'b1;
          result_o = src_bus_i[k*WORD_LENGTH +: WORD_LENGTH];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_operand_mux_reg.sv
// Registered N-source operand forwarding mux with held-value fallback and saturating no-match counter.
// Latency: 1 cycle from accept to out_valid; 1 transfer/cycle when out_ready is high.
// Backpressure: in_ready = ~flush & (~out_valid | out_ready); outputs freeze while stalled.
module fwd_operand_mux_reg
  import fwd_operand_mux_reg_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_SRC     = 4,
  parameter int ENC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int CNT_W       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  fwd_operand_mux_reg_if.slave        bus_if
);

  logic [WORD_LENGTH-1:0] data_q,     data_d;
  logic                   valid_q,    valid_d;
  logic                   nomatch_q,  nomatch_d;
  logic [CNT_W-1:0]       hold_q,     hold_d;
  logic [WORD_LENGTH-1:0] last_val_q, last_val_d;

  logic [WORD_LENGTH-1:0] result;
  logic                   match;
  logic                   in_ready;
  logic                   accept;

  fwd_sel_resolve #(
    .WORD_LENGTH (WORD_LENGTH),
    .NUM_SRC     (NUM_SRC),
    .ENC_W       (ENC_W)
  ) u_resolve (
    .src_bus_i   (bus_if.src_bus),
    .sel_mode_i  (bus_if.sel_mode),
    .sel_enc_i   (bus_if.sel_enc),
    .sel_oh_i    (bus_if.sel_oh),
    .last_val_i  (last_val_q),
    .result_o    (result),
    .match_o     (match)
  );

  assign in_ready = ~bus_if.flush & (~valid_q | bus_if.out_ready);
  assign accept   = bus_if.in_valid & in_ready;

  // Next-state: flush drops valid, accept loads, drained output goes invalid, else hold
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    nomatch_d  = nomatch_q;
    hold_d     = hold_q;
    last_val_d = last_val_q;
    if (bus_if.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      data_d    = result;
      valid_d   = 1'b1;
      nomatch_d = ~match;
      if (match) begin
        last_val_d = result;
        hold_d     = '0;
      end else if (hold_q != {CNT_W{1'b1}}) begin
        hold_d = hold_q + CNT_W'(1);
      end
    end else if (bus_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; the held value lives here so no-match never forms a combinational loop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      nomatch_q  <= 1'b0;
      hold_q     <= '0;
      last_val_q <= '0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      nomatch_q  <= nomatch_d;
      hold_q     <= hold_d;
      last_val_q <= last_val_d;
    end
  end

  assign bus_if.in_ready    = in_ready;
  assign bus_if.out_data    = data_q;
  assign bus_if.out_valid   = valid_q;
  assign bus_if.out_nomatch = nomatch_q;
  assign bus_if.hold_cnt    = hold_q;

endmodule

// File: tb/tb_fwd_operand_mux_reg.sv
// Directed bench for fwd_operand_mux_reg: a 4-source/4-bit-counter instance and a 3-source/2-bit-counter instance.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercised through out_ready stalls and flush.
module tb_fwd_operand_mux_reg;
  import fwd_operand_mux_reg_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fwd_operand_mux_reg_if #(.WORD_LENGTH(32), .NUM_SRC(4), .ENC_W(2), .CNT_W(4)) ifa ();
  fwd_operand_mux_reg_if #(.WORD_LENGTH(32), .NUM_SRC(3), .ENC_W(2), .CNT_W(2)) ifb ();

  fwd_operand_mux_reg #(.WORD_LENGTH(32), .NUM_SRC(4), .ENC_W(2), .CNT_W(4)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .bus_if (ifa)
  );

  fwd_operand_mux_reg #(.WORD_LENGTH(32), .NUM_SRC(3), .ENC_W(2), .CNT_W(2)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .bus_if (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;

    ifa.src_bus   = {32'h44, 32'h33, 32'h22, 32'h11};
    ifa.sel_mode  = SEL_MODE_ENC;
    ifa.sel_enc   = 2'd2;
    ifa.sel_oh    = 4'b0000;
    ifa.in_valid  = 1'b1;
    ifa.flush     = 1'b0;
    ifa.out_ready = 1'b1;

    ifb.src_bus   = {32'hC, 32'hB, 32'hA};
    ifb.sel_mode  = SEL_MODE_ENC;
    ifb.sel_enc   = 2'd0;
    ifb.sel_oh    = 3'b000;
    ifb.in_valid  = 1'b0;
    ifb.flush     = 1'b0;
    ifb.out_ready = 1'b1;

    #1;
    check("rst_a_data",    ifa.out_data,    0);
    check("rst_a_valid",   ifa.out_valid,   0);
    check("rst_a_nomatch", ifa.out_nomatch, 0);
    check("rst_a_hold",    ifa.hold_cnt,    0);
    check("rst_b_valid",   ifb.out_valid,   0);

    // 1: first encoded accept after reset release
    #6 rst = 1'b0;
    tick;
    check("t1_data",    ifa.out_data,    32'h33);
    check("t1_valid",   ifa.out_valid,   1);
    check("t1_nomatch", ifa.out_nomatch, 0);
    check("t1_hold",    ifa.hold_cnt,    0);

    // 2: one-hot priority, then three empty selects reuse the held value
    ifa.sel_mode = SEL_MODE_ONEHOT;
    ifa.sel_oh   = 4'b1010;
    tick;
    check("t2_prio_data",    ifa.out_data,    32'h22);
    check("t2_prio_nomatch", ifa.out_nomatch, 0);
    ifa.sel_oh = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      tick;
      check("t2_nm_data",    ifa.out_data,    32'h22);
      check("t2_nm_nomatch", ifa.out_nomatch, 1);
      check("t2_nm_hold",    ifa.hold_cnt,    i);
    end
    ifa.in_valid = 1'b0;
    tick;
    check("t2_idle_valid", ifa.out_valid, 0);
    check("t2_idle_hold",  ifa.hold_cnt,  3);
    check("t2_idle_data",  ifa.out_data,  32'h22);

    // 3: saturation of a 2-bit counter on out-of-range encoded selects
    ifb.in_valid = 1'b1;
    ifb.sel_enc  = 2'd0;
    tick;
    check("t3_seed_data", ifb.out_data, 32'hA);
    check("t3_seed_hold", ifb.hold_cnt, 0);
    ifb.sel_enc = 2'd3;
    for (int i = 1; i <= 5; i++) begin
      tick;
      check("t3_sat_hold",    ifb.hold_cnt,    (i > 3) ? 3 : i);
      check("t3_sat_data",    ifb.out_data,    32'hA);
      check("t3_sat_nomatch", ifb.out_nomatch, 1);
    end
    ifb.sel_enc = 2'd1;
    tick;
    check("t3_match_data",    ifb.out_data,    32'hB);
    check("t3_match_hold",    ifb.hold_cnt,    0);
    check("t3_match_nomatch", ifb.out_nomatch, 0);
    ifb.sel_enc = 2'd3;
    tick;
    check("t3_newlast_data", ifb.out_data, 32'hB);
    check("t3_newlast_hold", ifb.hold_cnt, 1);
    ifb.in_valid = 1'b0;

    // 4: backpressure holds data while sources change
    ifa.in_valid = 1'b1;
    ifa.sel_mode = SEL_MODE_ENC;
    ifa.sel_enc  = 2'd3;
    tick;
    check("t4_load_data",  ifa.out_data,  32'h44);
    check("t4_load_valid", ifa.out_valid, 1);
    check("t4_load_hold",  ifa.hold_cnt,  0);
    ifa.out_ready = 1'b0;
    ifa.sel_enc   = 2'd0;
    ifa.src_bus   = {32'h88, 32'h77, 32'h66, 32'h55};
    #1;
    check("t4_stall_inrdy", ifa.in_ready, 0);
    tick;
    check("t4_stall_data",  ifa.out_data,  32'h44);
    check("t4_stall_valid", ifa.out_valid, 1);
    ifa.src_bus = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
    tick;
    check("t4_stall2_data", ifa.out_data, 32'h44);
    ifa.out_ready = 1'b1;
    #1;
    check("t4_release_inrdy", ifa.in_ready, 1);
    tick;
    check("t4_release_data",  ifa.out_data,  32'hA1);
    check("t4_release_valid", ifa.out_valid, 1);

    // 5: flush beats a pending accept; last_val survives
    ifa.out_ready = 1'b0;
    ifa.flush     = 1'b1;
    ifa.sel_enc   = 2'd1;
    #1;
    check("t5_flush_inrdy", ifa.in_ready, 0);
    tick;
    check("t5_flush_valid", ifa.out_valid, 0);
    check("t5_flush_data",  ifa.out_data,  32'hA1);
    ifa.flush     = 1'b0;
    ifa.out_ready = 1'b1;
    ifa.sel_mode  = SEL_MODE_ONEHOT;
    ifa.sel_oh    = 4'b0000;
    tick;
    check("t5_post_data",    ifa.out_data,    32'hA1);
    check("t5_post_nomatch", ifa.out_nomatch, 1);
    check("t5_post_hold",    ifa.hold_cnt,    1);
    check("t5_post_valid",   ifa.out_valid,   1);

    // 6: asynchronous reset between clock edges
    ifa.in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("t6_arst_valid",   ifa.out_valid,   0);
    check("t6_arst_data",    ifa.out_data,    0);
    check("t6_arst_hold",    ifa.hold_cnt,    0);
    check("t6_arst_nomatch", ifa.out_nomatch, 0);
    check("t6_arst_b_data",  ifb.out_data,    0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
